// File: rtl/mac_pkg.sv
// Shared types and default sizing for the multiply-accumulate stage.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned MAC_DATA_W = 8;
  localparam int unsigned MAC_N      = 5;
  localparam int unsigned MAC_ACC_W  = 20;
  localparam int unsigned TERM_W     = 2 * MAC_DATA_W + 1;

  function automatic int unsigned term_width(input int unsigned data_w);
    return 2 * data_w + 1;
  endfunction

endpackage

// File: rtl/mac_term.sv
// Combinational a*b + c, zero-extended so the addend can never be lost.
module mac_term
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = MAC_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [2*DATA_W:0] term
);

  logic [2*DATA_W-1:0] prod;

  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  assign term = {1'b0, prod} + {{(DATA_W + 1){1'b0}}, c};

endmodule

// File: rtl/mac_accumulator.sv
// Multi-cycle MAC: after a start edge, sums a*b+c over N consecutive edges,
// pulses done for one cycle, then holds acc/cnt/ovf until the next run.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = MAC_DATA_W,
  parameter int unsigned N      = MAC_N,
  parameter int unsigned ACC_W  = MAC_ACC_W
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [ACC_W-1:0]  acc,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [7:0]        cnt
);

  localparam int unsigned TW    = term_width(DATA_W);
  // Sum is wide enough for either operand plus one carry bit, so a term wider
  // than the accumulator still flags overflow correctly.
  localparam int unsigned SUM_W = ((ACC_W > TW) ? ACC_W : TW) + 1;
  localparam logic [7:0]  LAST  = 8'(N - 1);

  state_t           state, state_next;
  logic             clear, accumulate;
  logic [TW-1:0]    term;
  logic [SUM_W-1:0] sum;
  logic             carry;

  mac_term #(.DATA_W(DATA_W)) u_term (
    .a    (a),
    .b    (b),
    .c    (c),
    .term (term)
  );

  assign sum   = SUM_W'(acc) + SUM_W'(term);
  assign carry = |sum[SUM_W-1:ACC_W];

  always_ff @(posedge ck or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    accumulate = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = ACC;
          clear      = 1'b1;
        end
      end
      ACC: begin
        accumulate = 1'b1;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        clear      = start;
        state_next = start ? ACC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accumulate) begin
      acc <= sum[ACC_W-1:0];
      cnt <= cnt + 8'd1;
      ovf <= ovf | carry;
    end
  end

  assign busy = (state == ACC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: default instance plus an 8-bit, N=1 instance.
module tb_mac_accumulator;

  logic        ck, rst, start, start_o;
  logic [7:0]  a, b, c;
  logic [19:0] acc;
  logic        busy, done, ovf;
  logic [7:0]  cnt;
  logic [7:0]  acc_o;
  logic        busy_o, done_o, ovf_o;
  logic [7:0]  cnt_o;

  int tests = 0;
  int fails = 0;

  logic [7:0]  sa [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
  logic [7:0]  sb [5] = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
  logic [7:0]  sc [5] = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
  logic [19:0] se [5] = '{20'd10, 20'd24, 20'd40, 20'd56, 20'd70};

  mac_accumulator dut (
    .ck(ck), .rst(rst), .start(start), .a(a), .b(b), .c(c),
    .acc(acc), .busy(busy), .done(done), .ovf(ovf), .cnt(cnt)
  );

  mac_accumulator #(.DATA_W(8), .N(1), .ACC_W(8)) dut_o (
    .ck(ck), .rst(rst), .start(start_o), .a(a), .b(b), .c(c),
    .acc(acc_o), .busy(busy_o), .done(done_o), .ovf(ovf_o), .cnt(cnt_o)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    tests++; if (acc !== 20'd0) begin fails++; $display("FAIL reset_acc got %0d want 0", acc); end
    tests++; if (cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    tests++; if ({busy, done, ovf} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {busy, done, ovf}); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (acc !== 20'd0 || cnt !== 8'd0 || {busy, done, ovf} !== 3'b000) begin
        fails++;
        $display("FAIL idle_hold cycle %0d got acc=%0d cnt=%0d flags=%b want 0 0 000", i, acc, cnt, {busy, done, ovf});
      end
    end
  endtask

  task automatic test_sequence(input bit pulse_mid);
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++; if (busy !== 1'b1 || acc !== 20'd0 || cnt !== 8'd0) begin fails++; $display("FAIL seq_start got busy=%b acc=%0d cnt=%0d want 1 0 0", busy, acc, cnt); end
    for (int i = 0; i < 5; i++) begin
      a = sa[i]; b = sb[i]; c = sc[i];
      start = (pulse_mid && i == 1);
      tick();
      start = 1'b0;
      tests++; if (acc !== se[i]) begin fails++; $display("FAIL seq_acc step %0d got %0d want %0d", i + 1, acc, se[i]); end
      tests++; if (cnt !== 8'(i + 1)) begin fails++; $display("FAIL seq_cnt step %0d got %0d want %0d", i + 1, cnt, i + 1); end
      if (i < 4) begin
        tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL seq_busy step %0d got busy=%b done=%b want 1 0", i + 1, busy, done); end
      end
    end
    tests++; if (done !== 1'b1 || busy !== 1'b0 || ovf !== 1'b0) begin fails++; $display("FAIL seq_done got done=%b busy=%b ovf=%b want 1 0 0", done, busy, ovf); end
    tick();
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL seq_pulse_len got done=%b busy=%b want 0 0", done, busy); end
    tests++; if (acc !== 20'd70 || cnt !== 8'd5) begin fails++; $display("FAIL seq_hold got acc=%0d cnt=%0d want 70 5", acc, cnt); end
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = sa[i]; b = sb[i]; c = sc[i];
      tick();
    end
    tests++; if (done !== 1'b1 || acc !== 20'd70) begin fails++; $display("FAIL b2b_first got done=%b acc=%0d want 1 70", done, acc); end
    start = 1'b1;
    a = 8'd2; b = 8'd3; c = 8'd1;
    tick();
    start = 1'b0;
    tests++; if (busy !== 1'b1 || done !== 1'b0 || acc !== 20'd0 || cnt !== 8'd0) begin
      fails++; $display("FAIL b2b_restart got busy=%b done=%b acc=%0d cnt=%0d want 1 0 0 0", busy, done, acc, cnt);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      tests++; if (acc !== 20'(7 * k)) begin fails++; $display("FAIL b2b_acc step %0d got %0d want %0d", k, acc, 7 * k); end
    end
    tests++; if (done !== 1'b1 || cnt !== 8'd5 || ovf !== 1'b0) begin fails++; $display("FAIL b2b_done got done=%b cnt=%0d ovf=%b want 1 5 0", done, cnt, ovf); end
    tick();
  endtask

  task automatic test_overflow();
    start_o = 1'b1;
    a = 8'd0; b = 8'd0; c = 8'd0;
    tick();
    start_o = 1'b0;
    tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL ovf_busy got %b want 1", busy_o); end
    a = 8'd255; b = 8'd255; c = 8'd255;
    tick();
    tests++; if (acc_o !== 8'd0) begin fails++; $display("FAIL ovf_acc got %0d want 0", acc_o); end
    tests++; if (ovf_o !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", ovf_o); end
    tests++; if (done_o !== 1'b1 || busy_o !== 1'b0 || cnt_o !== 8'd1) begin
      fails++; $display("FAIL ovf_done got done=%b busy=%b cnt=%0d want 1 0 1", done_o, busy_o, cnt_o);
    end
    tick();
    tests++; if (done_o !== 1'b0 || ovf_o !== 1'b1) begin fails++; $display("FAIL ovf_hold got done=%b ovf=%b want 0 1", done_o, ovf_o); end
  endtask

  task automatic test_reset_mid_run();
    bit seen_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = sa[i]; b = sb[i]; c = sc[i];
      tick();
    end
    tests++; if (acc !== 20'd24) begin fails++; $display("FAIL mid_pre got %0d want 24", acc); end
    #2 rst = 1'b1;
    #1;
    tests++; if (acc !== 20'd0 || busy !== 1'b0 || cnt !== 8'd0 || done !== 1'b0) begin
      fails++; $display("FAIL mid_async got acc=%0d busy=%b cnt=%0d done=%b want 0 0 0 0", acc, busy, cnt, done);
    end
    tick();
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    tests++; if (seen_done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mid_quiet got done_seen=%b busy=%b want 0 0", seen_done, busy); end
    test_sequence(1'b0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; start_o = 1'b0;
    a = '0; b = '0; c = '0;
    test_reset();
    test_sequence(1'b0);
    test_sequence(1'b1);
    test_back_to_back();
    test_overflow();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
